// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle control sequencer for the 8-bit MyCPU core.
//
// It fetches and decodes instructions from the memory data bus.
// It drives the program counter (stop / pc_jmp / ban_ebl / ban).
// It also drives the memory, accumulator and ALU strobes of the datapath.
// Only state, ir and the wait counter are registered.
// Every strobe is combinational from state, ir, the flags and mem_ready.
//
// Ports:
//   clk, rst              core clock; asynchronous active-high reset
//   run                   start request, honoured only in IDLE
//   mem_data[7:0]         memory read data (same bus as pc.data_in)
//   mem_ready             memory access completes this cycle
//   zero, carry           datapath flags, sampled when OPER completes
//   stop                  low for one cycle per PC advance
//   pc_jmp                PC loads the operand
//   ban_ebl, ban          relative-branch enable and taken
//   mem_rd, mem_wr        memory strobes
//   addr_sel              0 = address from PC, 1 = from operand register
//   opnd_load             latch mem_data into the operand register
//   acc_we, acc_src       accumulator write; source 0 = ALU, 1 = mem_data
//   alu_op[2:0]           ALU function (ir[6:4]) during EXEC
//   halted, fault         in HALT / FAULT; both are left only by reset
module ctrl_unit #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] mem_data,
    input  logic       mem_ready,
    input  logic       zero,
    input  logic       carry,
    output logic       stop,
    output logic       pc_jmp,
    output logic       ban_ebl,
    output logic       ban,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       opnd_load,
    output logic       acc_we,
    output logic       acc_src,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StOper, StExec, StMem, StHalt, StFault
    } state_e;

    localparam logic [3:0] WaitMax = 4'(WAIT_MAX);
    localparam logic [3:0] OpLd    = 4'h7;
    localparam logic [3:0] OpSt    = 4'h8;
    localparam logic [3:0] OpJmp   = 4'h9;
    localparam logic [3:0] OpBz    = 4'hA;
    localparam logic [3:0] OpBc    = 4'hB;
    localparam logic [3:0] OpLdi   = 4'hC;

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [3:0] opcode;
    logic       expired;

    assign opcode  = ir_q[7:4];
    // Last permitted wait cycle has passed without a response.
    assign expired = !mem_ready && (wcnt_q == WaitMax);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        // The counter is zero whenever it is not counting.
        // That clears it on entry to every memory-access state.
        wcnt_d    = 4'd0;
        stop      = 1'b1;
        pc_jmp    = 1'b0;
        ban_ebl   = 1'b0;
        ban       = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        addr_sel  = 1'b0;
        opnd_load = 1'b0;
        acc_we    = 1'b0;
        acc_src   = 1'b0;
        alu_op    = 3'd0;
        halted    = 1'b0;
        fault     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (expired) begin
                    state_d = StFault;
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_d    = mem_data;
                        stop    = 1'b0;
                        state_d = StDecode;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            StDecode: begin
                case (opcode)
                    4'h0, 4'hD, 4'hE:                   state_d = StFetch;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: state_d = StExec;
                    4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC: state_d = StOper;
                    default:                            state_d = StHalt;
                endcase
            end
            StOper: begin
                if (expired) begin
                    state_d = StFault;
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        stop    = 1'b0;
                        state_d = StFetch;
                        case (opcode)
                            OpJmp: pc_jmp = 1'b1;
                            OpBz: begin
                                ban_ebl = 1'b1;
                                ban     = zero;
                            end
                            OpBc: begin
                                ban_ebl = 1'b1;
                                ban     = carry;
                            end
                            OpLd, OpSt: begin
                                opnd_load = 1'b1;
                                state_d   = StMem;
                            end
                            OpLdi: begin
                                acc_we  = 1'b1;
                                acc_src = 1'b1;
                            end
                            default: ;
                        endcase
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            StExec: begin
                acc_we  = 1'b1;
                alu_op  = ir_q[6:4];
                state_d = StFetch;
            end
            StMem: begin
                if (expired) begin
                    state_d = StFault;
                end else begin
                    addr_sel = 1'b1;
                    if (opcode == OpLd) begin
                        mem_rd  = 1'b1;
                        acc_we  = mem_ready;
                        acc_src = mem_ready;
                    end else begin
                        mem_wr = 1'b1;
                    end
                    if (mem_ready) begin
                        state_d = StFetch;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            StHalt:  halted = 1'b1;
            StFault: fault  = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ir_q    <= 8'h00;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wcnt_q  <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit.
// The bench surrounds the sequencer with a PC, an operand register, an
// accumulator and a byte memory that react to its strobes.
// An instruction-level reference model predicts, for each instruction, the
// cycle count, the resulting PC and accumulator, and the strobe totals.
module tb_ctrl_unit;

    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic       zero;
    logic       carry;
    logic       stop;
    logic       pc_jmp;
    logic       ban_ebl;
    logic       ban;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       opnd_load;
    logic       acc_we;
    logic       acc_src;
    logic [2:0] alu_op;
    logic       halted;
    logic       fault;

    ctrl_unit #(.WAIT_MAX(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .zero      (zero),
        .carry     (carry),
        .stop      (stop),
        .pc_jmp    (pc_jmp),
        .ban_ebl   (ban_ebl),
        .ban       (ban),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .addr_sel  (addr_sel),
        .opnd_load (opnd_load),
        .acc_we    (acc_we),
        .acc_src   (acc_src),
        .alu_op    (alu_op),
        .halted    (halted),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Environment driven by the DUT strobes.
    logic [7:0] mem_env [256];
    logic [7:0] pc_env, opnd_env, acc_env;
    // Reference model state.
    logic [7:0] mem_ref [256];
    logic [7:0] pc_ref, acc_ref;

    // Memory latency plan: wait cycles for fetch, operand and data access.
    int   w [3];
    int   ai = 0;
    int   cur_wait = 0;
    bit   z_sel = 1'b0;
    bit   c_sel = 1'b0;

    // Per-instruction observations.
    int         k_cyc, n_stop, n_accwe, n_wr, n_wr_cyc, n_fetch_rd, stop_at;
    logic [2:0] last_alu;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        k_cyc = 0; n_stop = 0; n_accwe = 0; n_wr = 0; n_wr_cyc = 0;
        n_fetch_rd = 0; stop_at = -1; last_alu = 3'd0;
    endtask

    // One clock cycle: drive the inputs just after the edge, then sample on
    // the falling edge and let the environment respond.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_ready = (cur_wait == 0);
        if (mem_ready) begin
            mem_data = addr_sel ? mem_env[opnd_env] : mem_env[pc_env];
            zero     = z_sel;
            carry    = c_sel;
        end else begin
            // The bus carries garbage and the flags wander while memory is busy.
            mem_data = 8'($urandom);
            zero     = 1'($urandom);
            carry    = 1'($urandom);
        end
        @(negedge clk);
        check("jmp_ban_exclusive", 16'(pc_jmp & ban_ebl), 16'd0);
        if (!stop) check("stop_needs_ready", 16'(mem_ready), 16'd1);
        if (mem_rd && n_stop == 0) n_fetch_rd++;
        if (mem_wr && addr_sel) n_wr_cyc++;
        if (mem_wr && mem_ready) begin
            mem_env[opnd_env] = acc_env;
            n_wr++;
        end
        if (opnd_load) opnd_env = mem_data;
        if (acc_we) begin
            n_accwe++;
            if (acc_src) begin
                acc_env = mem_data;
            end else begin
                // Stand-in ALU result that records which function was applied.
                acc_env  = 8'hE0 | {5'd0, alu_op};
                last_alu = alu_op;
            end
        end
        if (!stop) begin
            if (n_stop == 0) stop_at = k_cyc;
            n_stop++;
            if (pc_jmp) pc_env = mem_data;
            else if (ban_ebl && ban) pc_env = pc_env + 8'd1 + mem_data;
            else pc_env = pc_env + 8'd1;
        end
        if (mem_rd || mem_wr) begin
            if (mem_ready) begin
                ai++;
                cur_wait = (ai < 3) ? w[ai] : 0;
            end else if (cur_wait > 0) begin
                cur_wait--;
            end
        end
        k_cyc++;
    endtask

    task automatic check_reset_outs(input string tag);
        check(tag, 16'({stop, pc_jmp, ban_ebl, ban, mem_rd, mem_wr, addr_sel, opnd_load,
                        acc_we, acc_src, alu_op, halted, fault}), 16'h4000);
    endtask

    // Asserted between clock edges so the outputs must react without a clock.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        run = 1'b0;
        #1;
        check_reset_outs(tag);
        #2;
        rst = 1'b0;
        pc_env = 8'd0; opnd_env = 8'd0; acc_env = 8'd0;
        pc_ref = 8'd0; acc_ref = 8'd0;
        cur_wait = 0; ai = 0;
        w[0] = 0; w[1] = 0; w[2] = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem_env[i] = 8'h00;
            mem_ref[i] = 8'h00;
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        mem_env[a] = d;
        mem_ref[a] = d;
    endtask

    // Predict one instruction from the ISA rules, execute it, compare.
    task automatic run_instr(input int wf, input int wo, input int wm, input bit z, input bit c);
        logic [7:0] b, o;
        logic [3:0] op;
        int n, e_stop, e_accwe, e_wr;
        b = mem_ref[pc_ref];
        o = mem_ref[pc_ref + 8'd1];
        op = b[7:4];
        e_stop = 2; e_accwe = 0; e_wr = 0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                n = 3 + wf; pc_ref = pc_ref + 8'd1; e_stop = 1; e_accwe = 1;
                acc_ref = 8'hE0 | {5'd0, op[2:0]};
            end
            4'h7: begin
                n = 4 + wf + wo + wm; pc_ref = pc_ref + 8'd2; e_accwe = 1;
                acc_ref = mem_ref[o];
            end
            4'h8: begin
                n = 4 + wf + wo + wm; pc_ref = pc_ref + 8'd2; e_wr = 1;
                mem_ref[o] = acc_ref;
            end
            4'h9: begin n = 3 + wf + wo; pc_ref = o; end
            4'hA: begin n = 3 + wf + wo; pc_ref = z ? pc_ref + 8'd2 + o : pc_ref + 8'd2; end
            4'hB: begin n = 3 + wf + wo; pc_ref = c ? pc_ref + 8'd2 + o : pc_ref + 8'd2; end
            4'hC: begin
                n = 3 + wf + wo; pc_ref = pc_ref + 8'd2; e_accwe = 1; acc_ref = o;
            end
            default: begin n = 2 + wf; pc_ref = pc_ref + 8'd1; e_stop = 1; end
        endcase
        w[0] = wf; w[1] = wo; w[2] = wm;
        ai = 0; cur_wait = wf; z_sel = z; c_sel = c;
        clear_obs();
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == 0) check("fetch_first_cycle", 16'({mem_rd, addr_sel}), 16'b10);
        end
        check("pc_after_instr", 16'(pc_env), 16'(pc_ref));
        check("acc_after_instr", 16'(acc_env), 16'(acc_ref));
        check("stop_pulses", 16'(n_stop), 16'(e_stop));
        check("acc_writes", 16'(n_accwe), 16'(e_accwe));
        check("mem_writes", 16'(n_wr), 16'(e_wr));
        if (op >= 4'h1 && op <= 4'h6) check("alu_op", 16'(last_alu), 16'(op[2:0]));
        if (op == 4'h8) check("st_data", 16'(mem_env[o]), 16'(mem_ref[o]));
    endtask

    task automatic directed(input string tag, input logic [7:0] at, input logic [7:0] b0,
                            input logic [7:0] b1, input bit z, input bit c,
                            input logic [7:0] exp_pc);
        do_reset("reset_outputs");
        clear_mem();
        poke(at, b0);
        poke(at + 8'd1, b1);
        run = 1'b1;
        pc_env = at;
        pc_ref = at;
        run_instr(0, 0, 0, z, c);
        check(tag, 16'(pc_env), 16'(exp_pc));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_data = 8'h00; mem_ready = 1'b0;
        zero = 1'b0; carry = 1'b0;
        clear_obs();
        #2;
        do_reset("reset_outputs_initial");

        // Idle without run: no strobes.
        clear_mem();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_rd", 16'({mem_rd, stop}), 16'b01);
        end

        // NOP stream: stop low every second cycle, PC = 5 after 10 cycles.
        run = 1'b1;
        clear_obs();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("nop_stop_pattern", 16'(stop), 16'(k % 2));
        end
        check("nop_pc", 16'(pc_env), 16'h05);

        // Branches, JMP.
        directed("bz_taken", 8'h10, 8'hA0, 8'h04, 1'b1, 1'b0, 8'h16);
        directed("bz_not_taken", 8'h10, 8'hA0, 8'h04, 1'b0, 1'b1, 8'h12);
        directed("bc_back", 8'h10, 8'hB0, 8'hFE, 1'b0, 1'b1, 8'h10);
        directed("bc_not_taken", 8'h10, 8'hB0, 8'hFE, 1'b1, 1'b0, 8'h12);
        directed("jmp", 8'h00, 8'h90, 8'h40, 1'b0, 1'b0, 8'h40);

        // LDI loads the immediate.
        directed("ldi_pc", 8'h00, 8'hC0, 8'h5A, 1'b0, 1'b0, 8'h02);
        check("ldi_acc", 16'(acc_env), 16'h5A);

        // ST: one write cycle from the operand address.
        do_reset("reset_outputs");
        clear_mem();
        poke(8'h00, 8'h80);
        poke(8'h01, 8'h33);
        acc_env = 8'h77;
        acc_ref = 8'h77;
        run = 1'b1;
        run_instr(0, 0, 0, 1'b0, 1'b0);
        check("st_wr_cycles", 16'(n_wr_cyc), 16'd1);
        check("st_mem", 16'(mem_env[8'h33]), 16'h77);
        check("st_pc", 16'(pc_env), 16'h02);

        // Three fetch wait cycles: mem_rd for 4 cycles, stop low on the 4th only.
        do_reset("reset_outputs");
        clear_mem();
        poke(8'h00, 8'hC0);
        poke(8'h01, 8'h21);
        run = 1'b1;
        run_instr(3, 0, 0, 1'b0, 1'b0);
        check("wait_fetch_rd", 16'(n_fetch_rd), 16'd4);
        check("wait_stop_at", 16'(stop_at), 16'd3);
        check("wait_acc", 16'(acc_env), 16'h21);

        // Operand never arrives: fault after 16 OPER cycles, PC unchanged.
        do_reset("reset_outputs");
        clear_mem();
        poke(8'h00, 8'h90);
        poke(8'h01, 8'h40);
        run = 1'b1;
        w[0] = 0; w[1] = 100000; w[2] = 0; ai = 0; cur_wait = 0;
        clear_obs();
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            check("timeout_oper_rd", 16'(mem_rd), 16'(i < 15));
            check("timeout_no_fault", 16'(fault), 16'd0);
        end
        tick();
        check("timeout_fault", 16'({fault, mem_rd}), 16'b10);
        check("timeout_pc", 16'(pc_env), 16'h01);
        tick();
        check("fault_sticky", 16'(fault), 16'd1);

        // HLT: halted, PC frozen, left only by reset.
        do_reset("reset_clears_fault");
        clear_mem();
        poke(8'h00, 8'hF0);
        run = 1'b1;
        run_instr(0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_state", 16'({halted, mem_rd}), 16'b10);
            check("halt_pc", 16'(pc_env), 16'h01);
        end
        do_reset("reset_mid_halt");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_after_reset", 16'({mem_rd, halted}), 16'b00);
        end
        run = 1'b1;
        tick();
        check("run_fetch", 16'({mem_rd, addr_sel}), 16'b10);

        // Reset in the middle of a stalled LD data access.
        do_reset("reset_outputs");
        clear_mem();
        poke(8'h00, 8'h70);
        poke(8'h01, 8'h50);
        run = 1'b1;
        w[0] = 0; w[1] = 0; w[2] = 100000; ai = 0; cur_wait = 0;
        for (int i = 0; i < 5; i++) tick();
        check("mem_stalled", 16'({mem_rd, addr_sel}), 16'b11);
        do_reset("reset_mid_mem");
        tick();
        check("idle_after_mem_reset", 16'(mem_rd), 16'd0);

        // Random program against the reference model.
        do_reset("reset_outputs");
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b[7:4] == 4'hF) b[7:4] = 4'h0;
            mem_env[i] = b;
            mem_ref[i] = b;
        end
        run = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int r0, r1, r2;
            r0 = $urandom_range(0, 7);
            r1 = $urandom_range(0, 7);
            r2 = $urandom_range(0, 7);
            run_instr(r0 > 3 ? 0 : r0, r1 > 3 ? 0 : r1, r2 > 3 ? 0 : r2,
                      1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
